// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core among NUM_REQ requesters.
// Latches the winner's operand, drives the core start/done handshake and routes the result back.
module ascon_perm_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_ROUNDS = 12,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*4-1:0]   req_rounds,
   input  logic [NUM_REQ*320-1:0] req_state,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [319:0]           rsp_state,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [2:0]             grant_id,
   output logic                   perm_start,
   output logic [3:0]             perm_rounds,
   output logic [319:0]           perm_state_in,
   input  logic                   perm_done,
   input  logic [319:0]           perm_state_out
);

   localparam int unsigned SW  = 320;
   localparam int unsigned RW  = 4;
   localparam int unsigned GW  = 3;
   localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [IDW-1:0]     last_q, last_d;
   logic [GW-1:0]      grant_q, grant_d;
   logic [RW-1:0]      rounds_q, rounds_d;
   logic [SW-1:0]      opnd_q, opnd_d;
   logic [SW-1:0]      rsp_state_q, rsp_state_d;
   logic               rsp_err_q, rsp_err_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               perm_start_q, perm_start_d;
   logic               busy_q, busy_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

   logic               win_vld_c;
   logic [IDW-1:0]     win_id_c;
   logic [IDW-1:0]     cand_c;
   logic [RW-1:0]      sel_rounds_c;
   logic [SW-1:0]      sel_state_c;
   logic [RW-1:0]      eff_rounds_c;
   logic               xfer_c;
   logic [NUM_REQ-1:0] ready_c;

   // Round-robin winner: first valid requester after the last owner, wrapping.
   always_comb begin : arb
      win_vld_c    = 1'b0;
      win_id_c     = '0;
      cand_c       = '0;
      sel_rounds_c = '0;
      sel_state_c  = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand_c = IDW'((32'(last_q) + off) % NUM_REQ);
         if (!win_vld_c && req_valid[cand_c]) begin
            win_vld_c = 1'b1;
            win_id_c  = cand_c;
         end
      end
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (win_id_c == IDW'(k)) begin
            sel_rounds_c = req_rounds[RW*k +: RW];
            sel_state_c  = req_state[SW*k +: SW];
         end
      end
   end

   assign eff_rounds_c = (sel_rounds_c > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : sel_rounds_c;
   assign xfer_c       = (state_q == IDLE) && win_vld_c;

   // Grant is combinational so the transfer completes in the first IDLE cycle.
   always_comb begin : ready_gen
      ready_c = '0;
      if (xfer_c) begin
         ready_c[win_id_c] = 1'b1;
      end
   end

   always_comb begin : fsm
      state_d      = state_q;
      last_d       = last_q;
      grant_d      = grant_q;
      rounds_d     = rounds_q;
      opnd_d       = opnd_q;
      rsp_state_d  = rsp_state_q;
      rsp_err_d    = rsp_err_q;
      cnt_d        = cnt_q;
      perm_start_d = 1'b0;
      busy_d       = 1'b0;
      rsp_valid_d  = '0;

      case (state_q)
         IDLE: begin
            if (xfer_c) begin
               opnd_d   = sel_state_c;
               rounds_d = eff_rounds_c;
               grant_d  = GW'(win_id_c);
               last_d   = win_id_c;
               if (eff_rounds_c == '0) begin
                  // Zero rounds is an identity permutation; skip the core.
                  rsp_state_d = sel_state_c;
                  rsp_err_d   = 1'b0;
                  state_d     = RESP;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (perm_done) begin
               rsp_state_d = perm_state_out;
               rsp_err_d   = 1'b0;
               state_d     = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_state_d = opnd_q;
               rsp_err_d   = 1'b1;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake outputs are registered from the next state so they align with it.
      perm_start_d = (state_d == ISSUE);
      busy_d       = (state_d != IDLE);
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         rsp_valid_d[k] = (state_d == RESP) && (grant_d == GW'(k));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : regs
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= IDW'(NUM_REQ - 1);
         grant_q      <= '0;
         rounds_q     <= '0;
         opnd_q       <= '0;
         rsp_state_q  <= '0;
         rsp_err_q    <= 1'b0;
         cnt_q        <= '0;
         perm_start_q <= 1'b0;
         busy_q       <= 1'b0;
         rsp_valid_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         grant_q      <= grant_d;
         rounds_q     <= rounds_d;
         opnd_q       <= opnd_d;
         rsp_state_q  <= rsp_state_d;
         rsp_err_q    <= rsp_err_d;
         cnt_q        <= cnt_d;
         perm_start_q <= perm_start_d;
         busy_q       <= busy_d;
         rsp_valid_q  <= rsp_valid_d;
      end
   end

   assign req_ready     = ready_c;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_state     = rsp_state_q;
   assign rsp_err       = rsp_err_q;
   assign busy          = busy_q;
   assign grant_id      = grant_q;
   assign perm_start    = perm_start_q;
   assign perm_rounds   = rounds_q;
   assign perm_state_in = opnd_q;

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Directed bench for ascon_perm_arbiter with a behavioural permutation core of programmable latency.
module tb_ascon_perm_arbiter;

   localparam int unsigned NR = 4;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR*4-1:0] req_rounds;
   logic [NR*320-1:0] req_state;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   rsp_valid;
   logic [319:0]    rsp_state;
   logic            rsp_err;
   logic            busy;
   logic [2:0]      grant_id;
   logic            perm_start;
   logic [3:0]      perm_rounds;
   logic [319:0]    perm_state_in;
   logic            perm_done;
   logic [319:0]    perm_state_out;

   logic            core_done;
   logic            spur_done;
   logic [319:0]    core_out;
   int              core_lat;
   bit              core_hang;
   int              start_cnt;
   logic [3:0]      seen_rounds;
   logic [319:0]    seen_state;

   int              checks;
   int              failures;

   assign perm_done      = core_done | spur_done;
   assign perm_state_out = core_out;

   ascon_perm_arbiter #(.NUM_REQ(NR), .MAX_ROUNDS(12), .TIMEOUT(64)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_rounds     (req_rounds),
      .req_state      (req_state),
      .req_ready      (req_ready),
      .rsp_valid      (rsp_valid),
      .rsp_state      (rsp_state),
      .rsp_err        (rsp_err),
      .busy           (busy),
      .grant_id       (grant_id),
      .perm_start     (perm_start),
      .perm_rounds    (perm_rounds),
      .perm_state_in  (perm_state_in),
      .perm_done      (perm_done),
      .perm_state_out (perm_state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in permutation: rotate left by one, mix in the round count and a constant.
   function automatic logic [319:0] core_fn(input logic [319:0] s, input logic [3:0] r);
      return {s[318:0], s[319]} ^ {316'h0, r} ^ 320'h5A5A;
   endfunction

   task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Core model: perm_done in the core_lat-th cycle after the start pulse.
   initial begin
      core_done   = 1'b0;
      core_out    = '0;
      start_cnt   = 0;
      seen_rounds = '0;
      seen_state  = '0;
      forever begin
         @(negedge clk);
         if (perm_start === 1'b1) begin
            start_cnt++;
            seen_rounds = perm_rounds;
            seen_state  = perm_state_in;
            if (!core_hang) begin
               repeat (core_lat) @(posedge clk);
               #1;
               core_out  = core_fn(seen_state, seen_rounds);
               core_done = 1'b1;
               @(posedge clk);
               #1;
               core_done = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_eq("rst_ctl", {busy, rsp_err, perm_start, grant_id, rsp_valid, req_ready, perm_rounds}, '0);
      check_eq("rst_rsp_state", rsp_state, '0);
      check_eq("rst_perm_state_in", perm_state_in, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Present one request, check its grant, and release after the transfer edge.
   task automatic start_req(input int k, input logic [3:0] rnd, input logic [319:0] st);
      logic [NR-1:0] oh;
      oh = NR'(1) << k;
      @(negedge clk);
      req_valid[k]            = 1'b1;
      req_rounds[4*k +: 4]    = rnd;
      req_state[320*k +: 320] = st;
      #1;
      check_eq("req_ready", req_ready, oh);
      @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
   endtask

   // Counts negedges until rsp_valid is seen; n = -1 if the budget expires.
   task automatic wait_rsp(input int maxc, output int n);
      int c;
      c = 0;
      n = -1;
      while (c < maxc) begin
         @(negedge clk);
         c++;
         if (rsp_valid != '0) begin
            n = c;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      int            n;
      int            st0;
      int            rv_cnt;
      logic [319:0]  sv;
      logic [NR-1:0] oh;

      checks     = 0;
      failures   = 0;
      rst_n      = 1'b1;
      req_valid  = '0;
      req_rounds = '0;
      req_state  = '0;
      spur_done  = 1'b0;
      core_lat   = 12;
      core_hang  = 1'b0;

      #1;
      do_reset();

      // Single request, 12 rounds, core latency 12.
      st0 = start_cnt;
      start_req(0, 4'd12, 320'h1);
      wait_rsp(100, n);
      check_eq("t1_latency", n, 14);
      check_eq("t1_rsp_valid", rsp_valid, 4'b0001);
      check_eq("t1_rsp_state", rsp_state, 320'h5A54);
      check_eq("t1_rsp_err", rsp_err, 1'b0);
      check_eq("t1_starts", start_cnt - st0, 1);
      check_eq("t1_perm_rounds", seen_rounds, 4'd12);
      check_eq("t1_grant_id", grant_id, 3'd0);
      @(negedge clk);
      check_eq("t1_pulse_end", {busy, rsp_valid}, '0);

      // Four requesters held valid: grants must rotate 0,1,2,3,0,1,2,3.
      do_reset();
      core_lat = 3;
      st0 = start_cnt;
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
         req_rounds[4*k +: 4]    = 4'd6;
         req_state[320*k +: 320] = 320'h100 + 320'(k);
      end
      req_valid = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         wait_rsp(50, n);
         oh = NR'(1) << (g % NR);
         check_eq("t2_rsp_valid", rsp_valid, oh);
         check_eq("t2_grant_id", grant_id, 3'(g % NR));
         check_eq("t2_rsp_state", rsp_state, core_fn(320'h100 + 320'(g % NR), 4'd6));
         if (g == 7) req_valid = '0;
      end
      check_eq("t2_starts", start_cnt - st0, 8);
      @(negedge clk);
      check_eq("t2_idle", busy, 1'b0);

      // Zero rounds bypasses the core; 15 rounds is clamped to 12.
      sv  = {10{32'hDEADBEEF}};
      st0 = start_cnt;
      start_req(2, 4'd0, sv);
      wait_rsp(10, n);
      check_eq("t3_bypass_latency", n, 1);
      check_eq("t3_bypass_valid", rsp_valid, 4'b0100);
      check_eq("t3_bypass_state", rsp_state, sv);
      check_eq("t3_bypass_err", rsp_err, 1'b0);
      check_eq("t3_bypass_nostart", start_cnt - st0, 0);
      core_lat = 2;
      start_req(1, 4'd15, 320'h0123_4567_89AB_CDEF);
      wait_rsp(20, n);
      check_eq("t3_clamp_latency", n, 4);
      check_eq("t3_clamp_rounds", seen_rounds, 4'd12);
      check_eq("t3_clamp_state", rsp_state, core_fn(320'h0123_4567_89AB_CDEF, 4'd12));

      // Core never answers: error response after 64 WAIT cycles, then normal service.
      core_hang = 1'b1;
      start_req(3, 4'd5, 320'hCAFE);
      wait_rsp(100, n);
      check_eq("t4_to_latency", n, 66);
      check_eq("t4_to_valid", rsp_valid, 4'b1000);
      check_eq("t4_to_err", rsp_err, 1'b1);
      check_eq("t4_to_state", rsp_state, 320'hCAFE);
      core_hang = 1'b0;
      core_lat  = 5;
      start_req(0, 4'd4, 320'h3);
      wait_rsp(30, n);
      check_eq("t4_next_latency", n, 7);
      check_eq("t4_next_err", rsp_err, 1'b0);
      check_eq("t4_next_state", rsp_state, 320'h5A58);

      // Reset during WAIT; the late perm_done must not produce a response.
      core_lat = 20;
      start_req(1, 4'd8, 320'h77);
      repeat (4) @(negedge clk);
      check_eq("t5_busy_wait", busy, 1'b1);
      do_reset();
      rv_cnt = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid != '0) rv_cnt++;
      end
      check_eq("t5_no_rsp", rv_cnt, 0);
      check_eq("t5_idle", busy, 1'b0);
      core_lat = 3;
      @(negedge clk);
      req_rounds[3:0]     = 4'd3;
      req_state[319:0]    = 320'h11;
      req_rounds[11:8]    = 4'd3;
      req_state[959:640]  = 320'h22;
      req_valid           = 4'b0101;
      #1;
      check_eq("t5_first_grant", req_ready, 4'b0001);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      wait_rsp(20, n);
      check_eq("t5_rsp0_valid", rsp_valid, 4'b0001);
      @(negedge clk);
      #1;
      check_eq("t5_second_grant", req_ready, 4'b0100);
      @(posedge clk);
      #1;
      req_valid[2] = 1'b0;
      wait_rsp(20, n);
      check_eq("t5_rsp2_valid", rsp_valid, 4'b0100);
      check_eq("t5_rsp2_state", rsp_state, core_fn(320'h22, 4'd3));

      // Spurious perm_done in IDLE and ISSUE is ignored.
      @(negedge clk);
      spur_done = 1'b1;
      @(posedge clk);
      #1;
      spur_done = 1'b0;
      @(negedge clk);
      check_eq("t6_idle_spur", {busy, rsp_valid}, '0);
      core_lat = 4;
      start_req(3, 4'd2, 320'h10);
      spur_done = 1'b1;
      @(negedge clk);
      check_eq("t6_issue_start", perm_start, 1'b1);
      @(posedge clk);
      #1;
      spur_done = 1'b0;
      wait_rsp(30, n);
      check_eq("t6_issue_latency", n, 5);
      check_eq("t6_issue_state", rsp_state, 320'h5A78);
      check_eq("t6_issue_err", rsp_err, 1'b0);

      // perm_done on the timeout cycle wins over the timeout.
      core_lat = 64;
      start_req(0, 4'd12, 320'h5);
      wait_rsp(100, n);
      check_eq("t6_edge_latency", n, 66);
      check_eq("t6_edge_err", rsp_err, 1'b0);
      check_eq("t6_edge_state", rsp_state, 320'h5A5C);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ascon_perm_arbiter.md
Name: ascon_perm_arbiter

Overview:
- Shares one Ascon permutation core among NUM_REQ requesters, e.g. init, encrypt, decrypt and finalization engines.
- Arbitrates with round-robin, latches the winner's 320-bit state and round count, and sequences the core through its start/done handshake.
- Returns the permuted state to the winning requester only.
- Sits between the AEAD engines and a single permutation instance so that only one permutation datapath is synthesised.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_ROUNDS, 12, largest legal round count; larger requests are clamped to this value.
- TIMEOUT, 64, number of cycles spent in WAIT with no perm_done before the request is aborted with an error.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request.
- req_rounds  input  NUM_REQ*4  round count per requester; requester k uses bits [4k+3:4k].
- req_state  input  NUM_REQ*320  state per requester; requester k uses bits [320k+319:320k], x0 in the MSBs.
- req_ready  output  NUM_REQ  grant; a transfer happens when req_valid[k] and req_ready[k] are both high.
- rsp_valid  output  NUM_REQ  one-cycle pulse to the owning requester.
- rsp_state  output  320  permuted state; valid while any rsp_valid bit is high.
- rsp_err  output  1  timeout flag; qualified by rsp_valid.
- busy  output  1  high in every state except IDLE.
- grant_id  output  3  index of the current or last owner.
- perm_start  output  1  one-cycle start pulse to the core.
- perm_rounds  output  4  round count sent to the core.
- perm_state_in  output  320  operand for the core; held stable from ISSUE until perm_done.
- perm_done  input  1  core completion.
- perm_state_out  input  320  core result; valid when perm_done is high.

Behaviour:
- Reset (rst_n is asynchronous, active-low; clock clk):
  - FSM goes to IDLE.
  - All outputs are 0: req_ready, rsp_valid, rsp_state, rsp_err, busy, grant_id, perm_start, perm_rounds, perm_state_in.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has priority first.
  - Watchdog counter = 0.
- Reset mid-operation aborts the operation silently. No rsp_valid is produced. perm_done arriving after reset is ignored, because the FSM is in IDLE.
- FSM states:
  - IDLE
    - Winner = first k with req_valid[k] set, scanning from last+1 and wrapping modulo NUM_REQ.
    - req_ready[winner] is asserted combinationally in this state; it is the only req_ready bit ever high.
    - On the transfer edge:
      - latch req_state and the effective rounds;
      - grant_id <= winner and last <= winner;
      - go to ISSUE, or to RESP when rounds = 0.
    - A requester must hold req_valid and its data stable until it sees req_ready.
  - ISSUE
    - perm_start = 1 for exactly one cycle; perm_rounds and perm_state_in come from the latches.
    - Clear the watchdog counter; go to WAIT.
  - WAIT
    - Count cycles. On perm_done: rsp_state <= perm_state_out, rsp_err <= 0, go to RESP.
    - If the count reaches TIMEOUT before perm_done: rsp_state <= latched input, rsp_err <= 1, go to RESP.
    - perm_done wins if it arrives on the same cycle the timeout is reached.
  - RESP
    - rsp_valid[grant_id] = 1 for exactly one cycle; go to IDLE.
    - rsp_state and rsp_err hold until the next response.
- Round rules:
  - Effective rounds = min(req_rounds, MAX_ROUNDS).
  - rounds = 0 bypasses the core: perm_start is not pulsed, rsp_state = input state, rsp_err = 0.
  - Bypass latency: transfer edge to rsp_valid = 1 cycle.
- Latency for a normal request: transfer edge, then ISSUE (1 cycle), then WAIT (core latency L cycles, including the perm_done cycle), then RESP.
  - Total from transfer edge to rsp_valid = L+2 cycles.
  - Minimum back-to-back issue interval per owner is L+3 cycles.
- Requests are not accepted in ISSUE, WAIT or RESP; all req_ready bits are 0 there.
- perm_done outside WAIT is ignored.
- A requester may raise req_valid again during its own RESP. It re-arbitrates in IDLE with its priority now lowest.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 grants.
- A single requester with no contention is granted on every pass through IDLE.

Test Plan:
- Reset then req_valid=0001, rounds=12, state=0x0..01; model core with L=12 → req_ready=0001 in the same cycle, one perm_start pulse, perm_rounds=12, rsp_valid=0001 exactly 14 cycles after the transfer edge, rsp_state = model output, rsp_err=0.
- req_valid=1111 held continuously for 8 grants, rounds=6 → grant_id sequence 0,1,2,3,0,1,2,3; each rsp_valid bit pulses only for its own requester; no overlap between grants.
- req_rounds=0 with state=0xDEADBEEF… → no perm_start, rsp_valid 1 cycle after transfer, rsp_state equals the input; req_rounds=15 → perm_rounds=12.
- Core model never asserts perm_done, TIMEOUT=64 → rsp_valid after 64 WAIT cycles, rsp_err=1, rsp_state equals the input; the next request proceeds normally.
- Assert rst_n=0 during WAIT, then perm_done arrives after release → all outputs 0, no rsp_valid, busy=0; the first post-reset grant goes to requester 0.
- Spurious perm_done in IDLE and ISSUE → ignored; perm_done on the same cycle as the timeout → rsp_err=0, rsp_state = perm_state_out.
